// File: rtl/lif_pkg.sv
// Shared definitions for the leaky integrate-and-fire neuron array:
// the post-spike reset-mode encoding, a saturating adder and a default threshold.
package lif_pkg;

    typedef enum int {
        RST_SUBTRACT = 0,
        RST_ZERO     = 1
    } reset_mode_e;

    // Suggested firing threshold for an 8-bit membrane.
    localparam int DEFAULT_THRESHOLD = 64;

    // Adds two sign-extended operands and clamps the sum to the signed range of
    // a w-bit number. The 32-bit working width holds the unclamped sum for any
    // w up to 30 bits.
    function automatic logic signed [31:0] sat_add(
        input logic signed [31:0] a,
        input logic signed [31:0] b,
        input int                 w
    );
        logic signed [31:0] sum;
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        sum = a + b;
        hi  = (32'sd1 <<< (w - 1)) - 32'sd1;
        lo  = -hi - 32'sd1;
        if (sum > hi) begin
            return hi;
        end else if (sum < lo) begin
            return lo;
        end
        return sum;
    endfunction

endpackage

// File: rtl/lif_update.sv
// Combinational next-state datapath for one neuron: leak, integrate with
// saturation, threshold compare, post-spike reset and refractory countdown.
module lif_update
    import lif_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int LEAK_SHIFT = 2,
    parameter int RESET_MODE = 0,
    parameter int REFRAC_W   = 4
) (
    input  logic signed [DATA_W-1:0]   mem_in,
    input  logic        [REFRAC_W-1:0] refr_in,
    input  logic signed [DATA_W-1:0]   current,
    input  logic signed [DATA_W-1:0]   threshold,
    input  logic        [REFRAC_W-1:0] refrac_cfg,
    output logic signed [DATA_W-1:0]   mem_out,
    output logic        [REFRAC_W-1:0] refr_out,
    output logic                       spk
);

    logic signed [DATA_W-1:0] decay;
    logic signed [DATA_W-1:0] sum_sat;
    logic signed [DATA_W-1:0] sub_sat;
    logic                     fire;

    // Leak/integrate/fire datapath; a refractory neuron ignores its input and
    // only counts down.
    always_comb begin
        // Leak never overflows: the subtracted term has the same sign and a
        // smaller magnitude than the membrane.
        decay   = mem_in - (mem_in >>> LEAK_SHIFT);
        sum_sat = DATA_W'(sat_add(32'(decay), 32'(current), DATA_W));
        sub_sat = DATA_W'(sat_add(32'(sum_sat), -32'(threshold), DATA_W));
        fire    = (sum_sat >= threshold);

        mem_out  = mem_in;
        refr_out = refr_in;
        spk      = 1'b0;
        if (refr_in != '0) begin
            refr_out = refr_in - 1'b1;
        end else if (fire) begin
            spk      = 1'b1;
            refr_out = refrac_cfg;
            mem_out  = (RESET_MODE == int'(RST_ZERO)) ? '0 : sub_sat;
        end else begin
            mem_out = sum_sat;
        end
    end

endmodule

// File: rtl/lif_neuron_array.sv
// Time-multiplexed array of leaky integrate-and-fire neurons. One event per
// accept updates the addressed neuron through a shared datapath and returns
// the result through a one-entry valid/ready output register.
module lif_neuron_array
    import lif_pkg::*;
#(
    parameter int  DATA_W      = 8,
    parameter int  NUM_NEURONS = 4,
    parameter int  LEAK_SHIFT  = 2,
    parameter int  RESET_MODE  = 0,
    parameter int  REFRAC_W    = 4,
    localparam int IDX_W       = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [DATA_W-1:0]   cfg_threshold,
    input  logic [REFRAC_W-1:0] cfg_refrac,
    input  logic                cfg_clear,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [IDX_W-1:0]    in_idx,
    input  logic [DATA_W-1:0]   in_current,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [IDX_W-1:0]    out_idx,
    output logic                out_spk,
    output logic [DATA_W-1:0]   out_mem
);

    localparam logic [IDX_W:0] NUM_LIMIT = (IDX_W + 1)'(NUM_NEURONS);

    logic signed [DATA_W-1:0]   mem_reg  [NUM_NEURONS];
    logic        [REFRAC_W-1:0] refr_reg [NUM_NEURONS];

    logic signed [DATA_W-1:0]   sel_mem;
    logic        [REFRAC_W-1:0] sel_refr;
    logic signed [DATA_W-1:0]   upd_mem;
    logic        [REFRAC_W-1:0] upd_refr;
    logic                       upd_spk;
    logic                       idx_ok;
    logic                       accept;

    logic                       out_valid_reg;
    logic [IDX_W-1:0]           out_idx_reg;
    logic                       out_spk_reg;
    logic [DATA_W-1:0]          out_mem_reg;

    assign in_ready = !cfg_clear && (!out_valid_reg || out_ready);
    assign accept   = in_valid && in_ready;
    assign idx_ok   = ({1'b0, in_idx} < NUM_LIMIT);

    // Select the addressed neuron's state; out-of-range indices read as zero.
    always_comb begin
        sel_mem  = '0;
        sel_refr = '0;
        for (int i = 0; i < NUM_NEURONS; i++) begin
            if (in_idx == IDX_W'(i)) begin
                sel_mem  = mem_reg[i];
                sel_refr = refr_reg[i];
            end
        end
    end

    lif_update #(
        .DATA_W     (DATA_W),
        .LEAK_SHIFT (LEAK_SHIFT),
        .RESET_MODE (RESET_MODE),
        .REFRAC_W   (REFRAC_W)
    ) u_update (
        .mem_in     (sel_mem),
        .refr_in    (sel_refr),
        .current    ($signed(in_current)),
        .threshold  ($signed(cfg_threshold)),
        .refrac_cfg (cfg_refrac),
        .mem_out    (upd_mem),
        .refr_out   (upd_refr),
        .spk        (upd_spk)
    );

    // Per-neuron state: cleared by reset or global clear, written on accept of
    // its own index so a following event already sees the new value.
    for (genvar gi = 0; gi < NUM_NEURONS; gi++) begin : g_neuron
        always_ff @(posedge clk) begin
            if (rst || cfg_clear) begin
                mem_reg[gi]  <= '0;
                refr_reg[gi] <= '0;
            end else if (accept && (in_idx == IDX_W'(gi))) begin
                mem_reg[gi]  <= upd_mem;
                refr_reg[gi] <= upd_refr;
            end
        end
    end

    // Result register: loads on accept, holds under backpressure, drains when
    // downstream takes it and nothing new arrives.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            out_idx_reg   <= '0;
            out_spk_reg   <= 1'b0;
            out_mem_reg   <= '0;
        end else if (accept) begin
            out_valid_reg <= 1'b1;
            out_idx_reg   <= in_idx;
            out_spk_reg   <= idx_ok && upd_spk;
            out_mem_reg   <= idx_ok ? upd_mem : '0;
        end else if (out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

    assign out_valid = out_valid_reg;
    assign out_idx   = out_idx_reg;
    assign out_spk   = out_spk_reg;
    assign out_mem   = out_mem_reg;

endmodule
